// File: rtl/dmem_stall_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data-memory sequencer.
// Holds the FSM state encoding and a counter-width helper.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 64;
  localparam int DMEM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

  // Counter width able to hold limit, never narrower than 8 bits.
  function automatic int cnt_width(input longint unsigned limit);
    int w;
    w = 8;
    for (int i = 8; i < 32; i++) begin
      if ((64'd1 << i) <= limit) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Data-memory request/response bus between the sequencer and memory.
// master = sequencer side, slave = memory / cache port side.
interface dmem_stall_ctrl_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid,
    output req_addr,
    output req_wen,
    output req_wdata,
    output req_wmask,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_wen,
    input  req_wdata,
    input  req_wmask,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );

endinterface

// File: rtl/dmem_watchdog.sv
// Response watchdog: clears while the request is pending, counts
// WAIT cycles, and flags the last allowed WAIT cycle as expired.
module dmem_watchdog
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = cnt_width(longint'(TIMEOUT));
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, otherwise count enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The TIMEOUT-th WAIT cycle without a response expires the access.
  assign expire_o = en_i & (cnt_q == LAST);

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory sequencer: turns a load/store into a bus
// request + response and drives mem_stall. Option: DMEM_TIMEOUT_EN.
module dmem_stall_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_W  = DMEM_ADDR_W,
  parameter int          DATA_W  = DMEM_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                mem_re,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_rdata,
`ifdef DMEM_TIMEOUT_EN
  output logic                mem_err,
`endif
  dmem_stall_ctrl_if.master   bus
);

  localparam int MW = DATA_W / 8;

  dmem_state_e       state_q;
  logic              req_valid_q;
  logic              req_wen_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [MW-1:0]     req_wmask_q;
  logic [DATA_W-1:0] rdata_q;

  logic access;
  logic expire;

  assign access = mem_re | mem_we;

`ifdef DMEM_TIMEOUT_EN
  logic err_q;

  dmem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (state_q == REQ),
    .en_i     (state_q == WAIT),
    .expire_o (expire)
  );

  // Error pulse for the DONE cycle of an access that timed out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == WAIT) & ~bus.resp_valid & expire;
    end
  end

  assign mem_err = err_q;
`else
  logic [31:0] unused_timeout;

  assign expire         = 1'b0;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  // Sequencer FSM with registered request fields and load data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
            req_wen_q   <= mem_we;
            req_addr_q  <= mem_addr;
            req_wdata_q <= mem_wdata;
            req_wmask_q <= mem_wmask;
          end
        end
        REQ: begin
          if (bus.req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.resp_valid) begin
            state_q <= DONE;
            if (!req_wen_q) begin
              rdata_q <= bus.resp_rdata;
            end
          end else if (expire) begin
            state_q <= DONE;
            rdata_q <= '0;
          end
        end
        DONE: begin
          // The departing instruction is still visible here; never reissue.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall the access cycle itself combinationally, then hold through WAIT.
  assign mem_stall = rstn & (((state_q == IDLE) & access) |
                             (state_q == REQ) |
                             (state_q == WAIT));

  assign mem_rdata     = rdata_q;
  assign bus.req_valid = req_valid_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wen   = req_wen_q;
  assign bus.req_wdata = req_wdata_q;
  assign bus.req_wmask = req_wmask_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Self-checking bench for dmem_stall_ctrl: vector table, corner
// sequences and randomized accesses against a transaction-level model.
module tb_dmem_stall_ctrl;
  import dmem_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;
`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          mem_re = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [MW-1:0] mem_wmask = '0;
  logic          mem_stall;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_TIMEOUT_EN
  logic          mem_err;
`endif

  dmem_stall_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_stall_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_stall (mem_stall),
    .mem_rdata (mem_rdata),
`ifdef DMEM_TIMEOUT_EN
    .mem_err   (mem_err),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    logic        ld;
    logic [63:0] a;
    logic [63:0] wd;
    logic [7:0]  wm;
    int          rdy;
    int          rsp;
    logic [63:0] rd;
    int          exp_st;
    int          exp_rq;
    logic [63:0] exp_rd;
    logic        b2b;
  } vec_t;

  // Plays one access as a reactive bus slave; returns in the DONE cycle.
  task automatic run_access(
    input  logic        ld,
    input  logic [63:0] a,
    input  logic [63:0] wd,
    input  logic [7:0]  wm,
    input  int          rdy_dly,
    input  int          rsp_dly,
    input  logic [63:0] rd,
    output int          stalls,
    output int          reqs,
    output logic        fok,
    output logic [63:0] rdo,
    output logic        fin,
    output logic        rv_done
  );
    int ph;
    int k;
    stalls  = 0;
    reqs    = 0;
    fok     = 1'b1;
    rdo     = '0;
    fin     = 1'b0;
    rv_done = 1'b0;
    ph      = 0;
    k       = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mem_re    = ld;
        mem_we    = ~ld;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wmask = wm;
      end
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = {$urandom, $urandom};
      if (bus.req_valid) begin
        reqs++;
        if (bus.req_addr !== a || bus.req_wen !== ~ld ||
            bus.req_wdata !== wd || bus.req_wmask !== wm) fok = 1'b0;
      end
      if (ph == 0 && bus.req_valid) begin
        if (k == rdy_dly) begin
          bus.req_ready = 1'b1;
          ph = 1;
          k  = 0;
        end else k++;
      end else if (ph == 1) begin
        if (k == rsp_dly) begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = rd;
          ph = 2;
        end else k++;
      end
      #1;
      if (!mem_stall) begin
        rdo     = mem_rdata;
        fin     = 1'b1;
        rv_done = bus.req_valid;
        break;
      end
      stalls++;
    end
  endtask

  // Pipeline has nothing for MEM; nothing may be requested or stalled.
  task automatic idle_cycles(input int n, input logic [63:0] exp_rd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      #1;
      chk("idle_stall", mem_stall, 0);
      chk("idle_req_valid", bus.req_valid, 0);
      chk("idle_rdata", mem_rdata, exp_rd);
    end
  endtask

  vec_t        vt[5];
  logic [63:0] model_rd;
  int          st;
  int          rq;
  logic        fok;
  logic [63:0] rdo;
  logic        fin;
  logic        rvd;

  task automatic check_access(input string tag, input int exp_st,
                              input int exp_rq, input logic [63:0] exp_rd);
    chk({tag, "_finished"}, fin, 1);
    chk({tag, "_stall_cycles"}, st, exp_st);
    chk({tag, "_req_cycles"}, rq, exp_rq);
    chk({tag, "_fields"}, fok, 1);
    chk({tag, "_rdata"}, rdo, exp_rd);
    chk({tag, "_done_req_valid"}, rvd, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 64'h1000, 64'h0, 8'h00, 0, 0,
              64'hDEADBEEF_CAFEF00D, 3, 1, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vt[1] = '{1'b0, 64'h80, 64'h11, 8'h01, 4, 0,
              64'h5555_5555_5555_5555, 7, 5, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vt[2] = '{1'b1, 64'h2008, 64'h0, 8'h00, 1, 3,
              64'h01234567_89ABCDEF, 7, 2, 64'h01234567_89ABCDEF, 1'b1};
    vt[3] = '{1'b0, 64'h3000, 64'hAAAA_0000_BBBB_1111, 8'hF0, 0, 2,
              64'hFFFF_FFFF_FFFF_FFFF, 5, 1, 64'h01234567_89ABCDEF, 1'b0};
    vt[4] = '{1'b1, 64'h4010, 64'h0, 8'h00, 2, 0,
              64'h0, 5, 3, 64'h0, 1'b0};

    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;

    // Reset held with an access pending.
    mem_re = 1'b1;
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_req_valid", bus.req_valid, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_req_addr", bus.req_addr, 0);
    chk("rst_req_wen", bus.req_wen, 0);
    chk("rst_req_wdata", bus.req_wdata, 0);
    chk("rst_req_wmask", bus.req_wmask, 0);
`ifdef DMEM_TIMEOUT_EN
    chk("rst_mem_err", mem_err, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_held_stall", mem_stall, 0);
    chk("rst_held_req_valid", bus.req_valid, 0);
    mem_re = 1'b0;
    rstn   = 1'b1;
    model_rd = '0;
    idle_cycles(1, model_rd);

    // Directed vector table.
    for (int i = 0; i < 5; i++) begin
      run_access(vt[i].ld, vt[i].a, vt[i].wd, vt[i].wm, vt[i].rdy,
                 vt[i].rsp, vt[i].rd, st, rq, fok, rdo, fin, rvd);
      check_access($sformatf("vec%0d", i), vt[i].exp_st, vt[i].exp_rq,
                   vt[i].exp_rd);
      if (!vt[i].b2b) idle_cycles(1, vt[i].exp_rd);
    end
    model_rd = vt[4].exp_rd;

    // Spurious responses while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      chk("spur_stall", mem_stall, 0);
      chk("spur_req_valid", bus.req_valid, 0);
    end
    idle_cycles(1, model_rd);
    run_access(1'b1, 64'h50, 64'h0, 8'h00, 0, 0, 64'h77, st, rq, fok, rdo,
               fin, rvd);
    check_access("post_spur", 3, 1, 64'h77);
    idle_cycles(1, 64'h77);

    // Reset pulsed during WAIT, stale response afterwards.
    @(negedge clk);
    mem_re   = 1'b1;
    mem_addr = 64'h60;
    @(negedge clk);
    bus.req_ready = 1'b1;
    #1;
    chk("rstw_req_valid_pre", bus.req_valid, 1);
    @(negedge clk);
    bus.req_ready = 1'b0;
    #1;
    chk("rstw_wait_stall", mem_stall, 1);
    rstn = 1'b0;
    #1;
    chk("rstw_stall", mem_stall, 0);
    chk("rstw_req_valid", bus.req_valid, 0);
    chk("rstw_rdata", mem_rdata, 0);
    @(negedge clk);
    mem_re = 1'b0;
    rstn   = 1'b1;
    @(negedge clk);
    bus.resp_valid = 1'b1;
    bus.resp_rdata = 64'h57A1E;
    #1;
    chk("rstw_stale_stall", mem_stall, 0);
    @(negedge clk);
    bus.resp_valid = 1'b0;
    #1;
    chk("rstw_stale_rdata", mem_rdata, 0);
    chk("rstw_stale_req_valid", bus.req_valid, 0);
    chk("rstw_stale_stall2", mem_stall, 0);
    model_rd = '0;
    run_access(1'b1, 64'h68, 64'h0, 8'h00, 0, 0, 64'h99, st, rq, fok, rdo,
               fin, rvd);
    check_access("post_rst", 3, 1, 64'h99);
    model_rd = 64'h99;
    idle_cycles(1, model_rd);

`ifdef DMEM_TIMEOUT_EN
    // No response ever: IDLE + REQ + TO WAIT cycles, then error DONE.
    run_access(1'b1, 64'h700, 64'h0, 8'h00, 0, 1000, 64'h1, st, rq, fok,
               rdo, fin, rvd);
    check_access("tmo", 2 + int'(TO), 1, 64'h0);
    chk("tmo_err_done", mem_err, 1);
    model_rd = '0;
    idle_cycles(1, model_rd);
    chk("tmo_err_after", mem_err, 0);
    run_access(1'b1, 64'h708, 64'h0, 8'h00, 0, 3, 64'h42, st, rq, fok,
               rdo, fin, rvd);
    check_access("tmo_ok", 6, 1, 64'h42);
    chk("tmo_ok_err", mem_err, 0);
    model_rd = 64'h42;
    idle_cycles(1, model_rd);
`endif

    // Randomized accesses against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      logic        ld;
      logic [63:0] a;
      logic [63:0] wd;
      logic [7:0]  wm;
      logic [63:0] rd;
      int          rdy;
      int          rsp;
      ld  = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      wd  = {$urandom, $urandom};
      wm  = 8'($urandom);
      rd  = {$urandom, $urandom};
      rdy = int'($urandom_range(0, 4));
      rsp = int'($urandom_range(0, 5));
      if (ld) model_rd = rd;
      run_access(ld, a, wd, wm, rdy, rsp, rd, st, rq, fok, rdo, fin, rvd);
      check_access($sformatf("rnd%0d", i), 3 + rdy + rsp, rdy + 1,
                   model_rd);
      if ($urandom_range(0, 1) == 0) idle_cycles(1, model_rd);
    end
    idle_cycles(2, model_rd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
